logic_reduce_unit: RTL

Parametrised, registered successor to the team's two-input AND cell. It applies a selectable bitwise operation (AND/OR/XOR/PASS) to WIDTH-bit operands. In single mode it returns one result per input beat. In accumulate mode it folds a burst of beats into one result. Valid/ready handshakes sit on both sides, so the unit drops into streaming datapaths that previously used the bare combinational gate.

---
 rtl/logic_reduce_unit.sv | 66 ++++++
 1 files changed

// File: rtl/logic_reduce_unit.sv
// logic_reduce_unit: registered AND/OR/XOR/PASS unit with single and burst-fold modes
module logic_reduce_unit #(
  parameter int WIDTH = 8,
  parameter int MAX_BEATS = 16,
  parameter int CW = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_accum,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_trunc
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;
  state_e state_q;
  logic [WIDTH-1:0] acc_q;
  logic [1:0] op_q;
  logic [CW-1:0] cnt_q;
  logic trunc_q;
  logic fire, start, at_max;
  logic [CW-1:0] cnt_inc;
  function automatic logic [WIDTH-1:0] apply(input logic [1:0] op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return op == 2'b00 ? (x & y) : op == 2'b01 ? (x | y) : op == 2'b10 ? (x ^ y) : x;
  endfunction
  assign in_ready = (state_q != HOLD) | out_ready;
  assign fire = in_valid & in_ready;
  // a beat arriving outside ACCUM (IDLE, or HOLD being drained) always opens a new result
  assign start = fire & (state_q != ACCUM);
  assign cnt_inc = cnt_q + 1'b1;
  assign at_max = cnt_inc == CW'(MAX_BEATS);
  assign out_valid = state_q == HOLD;
  assign out_data = acc_q;
  assign out_count = cnt_q;
  assign out_trunc = trunc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      op_q <= 2'b00;
      cnt_q <= '0;
      trunc_q <= 1'b0;
    end else if (start) begin
      acc_q <= apply(in_op, in_a, in_b);
      op_q <= in_op;
      cnt_q <= CW'(1);
      trunc_q <= 1'b0;
      state_q <= (in_accum & ~in_last) ? ACCUM : HOLD;
    end else if (fire) begin
      // new beat goes first so PASS keeps the most recent in_a
      acc_q <= apply(op_q, in_a, acc_q);
      cnt_q <= cnt_inc;
      trunc_q <= ~in_last & at_max;
      state_q <= (in_last | at_max) ? HOLD : ACCUM;
    end else if (state_q == HOLD && out_ready) begin
      state_q <= IDLE;
    end
  end
endmodule
